dsi_tx_rgb_packer: RTL and testbench

- Upstream neighbour of the DSI TX pixel buffer; sits in the system clock domain and drives that buffer's 32-bit Avalon-ST sink.
- Accepts one RGB888 pixel per beat on a 24-bit Avalon-ST sink.
- Packs the pixel byte stream densely into 32-bit words: 4 pixels become 3 words, with no padding inside a line.
- At end of line, flushes any partial word zero-padded; sop/eop mark the first and last word of each line.

---
 rtl/dsi_tx_rgb_packer.sv | 124 ++++++++++++
 tb/tb_dsi_tx_rgb_packer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dsi_tx_rgb_packer.sv
// dsi_tx_rgb_packer: packs a 24-bit RGB888 Avalon-ST pixel stream densely into 32-bit words per line.
// Optional line-length checking with sticky line_err is enabled by DSI_TX_RGB_PACKER_LINE_CHECK_EN.
module dsi_tx_rgb_packer
`ifdef DSI_TX_RGB_PACKER_LINE_CHECK_EN
  #(parameter int LINE_PIXELS = 480)
`endif
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] avl_st_in_data,
  input  logic        avl_st_in_valid,
  input  logic        avl_st_in_startofpacket,
  input  logic        avl_st_in_endofpacket,
  output logic        avl_st_in_ready,
  output logic [31:0] avl_st_out_data,
  output logic        avl_st_out_valid,
  output logic        avl_st_out_startofpacket,
  output logic        avl_st_out_endofpacket,
  input  logic        avl_st_out_ready
`ifdef DSI_TX_RGB_PACKER_LINE_CHECK_EN
  ,
  output logic        line_err
`endif
);
  typedef enum logic {RUN, FLUSH} state_e;
  state_e      state_q, state_d;
  logic        ready_en_q;
  logic [47:0] acc_q, acc_d, acc_in;
  logic [2:0]  cnt_q, cnt_d, cnt_base, cnt_new;
  logic        first_q, first_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
  logic        accept, slot_free, sop_in, eop_in;
  assign sop_in          = avl_st_in_startofpacket;
  assign eop_in          = avl_st_in_endofpacket;
  assign slot_free       = !valid_q | avl_st_out_ready;
  assign avl_st_in_ready = ready_en_q & (state_q == RUN) & slot_free;
  assign accept          = avl_st_in_valid & avl_st_in_ready;
  // A sop pixel discards any stale partial bytes before appending.
  assign cnt_base = sop_in ? 3'd0 : cnt_q;
  assign cnt_new  = cnt_base + 3'd3;
  assign acc_in   = (sop_in ? 48'd0 : acc_q) | (48'(avl_st_in_data) << {cnt_base, 3'b000});
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    data_d  = data_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    valid_d = valid_q & !avl_st_out_ready;
    if (state_q == FLUSH) begin
      if (slot_free) begin
        valid_d = 1'b1;
        data_d  = acc_q[31:0];
        sop_d   = 1'b0;
        eop_d   = 1'b1;
        acc_d   = 48'd0;
        cnt_d   = 3'd0;
        state_d = RUN;
      end
    end else if (accept) begin
      first_d = first_q | sop_in;
      acc_d   = acc_in;
      cnt_d   = cnt_new;
      if (cnt_new[2] || eop_in) begin
        valid_d = 1'b1;
        sop_d   = first_d;
        first_d = 1'b0;
        data_d  = cnt_new[2] ? acc_in[31:0] : {8'h00, acc_in[23:0]};
        eop_d   = eop_in && cnt_new <= 3'd4;
        acc_d   = cnt_new[2] ? acc_in >> 32 : 48'd0;
        cnt_d   = cnt_new[2] ? cnt_new - 3'd4 : 3'd0;
        // Leftover 1-2 bytes of an eop pixel go out in a dedicated flush word.
        state_d = (eop_in && cnt_new > 3'd4) ? FLUSH : RUN;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      ready_en_q <= 1'b0;
      acc_q      <= 48'd0;
      cnt_q      <= 3'd0;
      first_q    <= 1'b0;
      data_q     <= 32'd0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
    end
  end
  assign avl_st_out_data          = data_q;
  assign avl_st_out_valid         = valid_q;
  assign avl_st_out_startofpacket = sop_q;
  assign avl_st_out_endofpacket   = eop_q;
`ifdef DSI_TX_RGB_PACKER_LINE_CHECK_EN
  logic [15:0] pix_q, pix_next;
  logic        open_q, err_q;
  assign pix_next = sop_in ? 16'd1 : pix_q + 16'd1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q  <= 16'd0;
      open_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (accept) begin
      pix_q  <= pix_next;
      open_q <= eop_in ? 1'b0 : (sop_in | open_q);
      if ((eop_in && pix_next != 16'(LINE_PIXELS)) || (sop_in && open_q))
        err_q <= 1'b1;
    end
  end
  assign line_err = err_q;
`endif
endmodule

// File: tb/tb_dsi_tx_rgb_packer.sv
// tb_dsi_tx_rgb_packer: directed and randomized checks of the RGB888-to-32-bit packer against a byte-queue model.
module tb_dsi_tx_rgb_packer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] in_data = '0;
  logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, in_ready;
  logic [31:0] out_data;
  logic        out_valid, out_sop, out_eop;
  logic        out_ready = 1'b1;
  logic        rnd = 1'b0;
  int          checks = 0, errors = 0, nwords = 0, neops = 0;
  logic [7:0]  bq[$];
  logic [33:0] expq[$];
  logic        pend_sop = 1'b0;
`ifdef DSI_TX_RGB_PACKER_LINE_CHECK_EN
  logic        line_err;
  dsi_tx_rgb_packer #(.LINE_PIXELS(4)) dut (
`else
  dsi_tx_rgb_packer dut (
`endif
    .clk(clk), .rst_n(rst_n),
    .avl_st_in_data(in_data), .avl_st_in_valid(in_valid),
    .avl_st_in_startofpacket(in_sop), .avl_st_in_endofpacket(in_eop),
    .avl_st_in_ready(in_ready),
    .avl_st_out_data(out_data), .avl_st_out_valid(out_valid),
    .avl_st_out_startofpacket(out_sop), .avl_st_out_endofpacket(out_eop),
    .avl_st_out_ready(out_ready)
`ifdef DSI_TX_RGB_PACKER_LINE_CHECK_EN
    , .line_err(line_err)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic pick();
    return rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
  endfunction
  // Line-level model: the line is a byte stream cut into 4-byte words, last word zero-padded.
  function automatic void model_push(logic [23:0] d, logic s, logic e);
    logic [31:0] w;
    if (s) begin
      bq.delete();
      pend_sop = 1'b1;
    end
    for (int i = 0; i < 3; i++) bq.push_back(d[8*i +: 8]);
    while (bq.size() >= 4) begin
      w = {bq[3], bq[2], bq[1], bq[0]};
      repeat (4) void'(bq.pop_front());
      expq.push_back({w, pend_sop, e && bq.size() == 0});
      pend_sop = 1'b0;
    end
    if (e && bq.size() > 0) begin
      w = '0;
      for (int i = 0; i < bq.size(); i++) w[8*i +: 8] = bq[i];
      bq.delete();
      expq.push_back({w, pend_sop, 1'b1});
      pend_sop = 1'b0;
    end
  endfunction
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (expq.size() == 0) chk("extra_word", 64'(expq.size()), 64'd1);
      else chk("word", 64'({out_data, out_sop, out_eop}), 64'(expq.pop_front()));
      nwords++;
      if (out_eop) neops++;
    end
  end
  task automatic send(input logic [23:0] d, input logic s, input logic e);
    int   n = 0;
    logic got = 1'b0;
    in_data = d; in_sop = s; in_eop = e; in_valid = 1'b1;
    while (!got && n < 200) begin
      @(negedge clk);
      got = in_ready;
      if (got) model_push(d, s, e);
      @(posedge clk); #1;
      out_ready = pick();
      n++;
    end
    if (!got) chk("accept_timeout", 64'(n), 64'd0);
    in_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (expq.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 64'(expq.size()), 64'd0);
  endtask
  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    expq.delete(); bq.delete(); pend_sop = 1'b0;
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out", 64'({out_data, out_valid, out_sop, out_eop}), 64'd0);
`ifdef DSI_TX_RGB_PACKER_LINE_CHECK_EN
    chk("rst_line_err", 64'(line_err), 64'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("ready_before_edge", 64'(in_ready), 64'd0);
    @(negedge clk) chk("ready_after_edge", 64'(in_ready), 64'd1);
  endtask
  task automatic line(input int len, input logic with_sop, input logic [7:0] base);
    for (int k = 0; k < len; k++)
      send({base + 8'(3*k+2), base + 8'(3*k+1), base + 8'(3*k)}, with_sop && k == 0, k == len - 1);
  endtask
  initial begin
    int w0, e0, len;
    logic [31:0] cap;
    do_reset();
    w0 = nwords;
    send(24'h030201, 1, 0); send(24'h060504, 0, 0); send(24'h090807, 0, 0); send(24'h0C0B0A, 0, 1);
    @(negedge clk) chk("l4_no_flush_ready", 64'(in_ready), 64'd1);
    drain();
    chk("l4_words", 64'(nwords - w0), 64'd3);
    w0 = nwords;
    send(24'hCCBBAA, 1, 1);
    drain();
    chk("l1_words", 64'(nwords - w0), 64'd1);
    w0 = nwords;
    send(24'h030201, 1, 0); send(24'h060504, 0, 1);
    @(negedge clk) chk("l2_flush_ready_low", 64'(in_ready), 64'd0);
    @(negedge clk) chk("l2_ready_back", 64'(in_ready), 64'd1);
    drain();
    chk("l2_words", 64'(nwords - w0), 64'd2);
    w0 = nwords;
    send(24'h030201, 1, 0); send(24'h060504, 0, 0); send(24'h112233, 1, 1);
    drain();
    chk("stale_words", 64'(nwords - w0), 64'd2);
    rnd = 1'b1;
    w0 = nwords; e0 = neops;
    for (int i = 0; i < 480; i++) begin
      send(24'($urandom), i == 0, i == 479);
      if (i == 99) begin
        out_ready = 1'b0;
        cap = out_data;
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          chk("bp_in_ready", 64'(in_ready), 64'd0);
          chk("bp_valid", 64'(out_valid), 64'd1);
          chk("bp_data_stable", 64'(out_data), 64'(cap));
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    end
    drain();
    chk("l480_words", 64'(nwords - w0), 64'd360);
    chk("l480_eops", 64'(neops - e0), 64'd1);
    for (int l = 0; l < 25; l++) begin
      len = $urandom_range(1, 13);
      for (int k = 0; k < len; k++) begin
        send(24'($urandom), k == 0 && l % 7 != 3, k == len - 1);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
          out_ready = pick();
        end
      end
    end
    drain();
    rnd = 1'b0;
    send(24'h0A0B0C, 1, 0); send(24'h0D0E0F, 0, 0); send(24'h101112, 0, 0);
    rst_n = 1'b0;
    #2 chk("async_rst_valid", 64'(out_valid), 64'd0);
    do_reset();
    w0 = nwords;
    line(4, 1, 8'h40);
    drain();
    chk("post_rst_words", 64'(nwords - w0), 64'd3);
`ifdef DSI_TX_RGB_PACKER_LINE_CHECK_EN
    do_reset();
    line(4, 1, 8'h10);
    drain();
    chk("err_good_line", 64'(line_err), 64'd0);
    line(3, 1, 8'h20);
    drain();
    chk("err_short_line", 64'(line_err), 64'd1);
    line(4, 1, 8'h30);
    drain();
    chk("err_sticky", 64'(line_err), 64'd1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
